// File: rtl/axi_rr_addr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rr_addr_arbiter
//
// Round-robin arbiter for one AXI address channel (AW or AR). It picks one
// requesting master per arbitration and decodes that master's address into a
// slave index. It also limits how many granted-but-uncompleted transactions
// each master may have in flight. The registered grant/sel outputs steer the
// slave-side address mux.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-low reset
//   req          per-master request, held high until the address transfer ends
//   addr         flattened addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   done         one-cycle pulse per completed transaction of master i
//   grant        registered one-hot grant
//   grant_id     index of the granted master (holds after release)
//   sel          decoded slave index of the granted master (holds after release)
//   dec_err      granted address decodes beyond NUM_SLAVES-1
//   busy         a grant is active
//   outstanding  flattened per-master outstanding-transaction counters
// ---------------------------------------------------------------------------
module axi_rr_addr_arbiter #(
    parameter int NUM_MASTERS     = 4,
    parameter int NUM_SLAVES      = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int MW = $clog2(NUM_MASTERS),
    localparam int SW = $clog2(NUM_SLAVES),
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_MASTERS-1:0]        done,
    output logic [NUM_MASTERS-1:0]        grant,
    output logic [MW-1:0]                 grant_id,
    output logic [SW-1:0]                 sel,
    output logic                          dec_err,
    output logic                          busy,
    output logic [NUM_MASTERS*CW-1:0]     outstanding
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [MW-1:0]          ptr;
    logic [CW-1:0]          cnt     [NUM_MASTERS];
    logic [SW-1:0]          top_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] elig_p0;
    logic                   found_p0;
    logic [MW-1:0]          win_p0;
    logic [MW-1:0]          cand;
    logic                   take;
    logic                   release_g;

    // A grant and a completion in the same cycle cancel out; a completion
    // against an empty counter is dropped so the count saturates at zero.
    function automatic logic [CW-1:0] cnt_update(input logic [CW-1:0] c,
                                                 input logic          inc,
                                                 input logic          dec);
        logic dec_ok;
        dec_ok = dec && (c != '0);
        if (inc && !dec_ok)
            return c + 1'b1;
        if (!inc && dec_ok)
            return c - 1'b1;
        return c;
    endfunction

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        assign top_idx[i] = addr[i*ADDR_WIDTH + ADDR_WIDTH - 1 -: SW];
        // A master at its cap stays out of arbitration until a done frees a slot.
        assign elig_p0[i] = req[i] && (cnt[i] != CW'(MAX_OUTSTANDING));
        assign outstanding[i*CW +: CW] = cnt[i];
    end

    // ---- stage p0: combinational round-robin search starting at ptr ----
    // Scanning from the far end backwards lets the candidate closest to ptr
    // overwrite the others, giving the first eligible index in rotation order.
    always_comb begin
        found_p0 = 1'b0;
        win_p0   = '0;
        cand     = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            cand = MW'((int'(ptr) + k) % NUM_MASTERS);
            if (elig_p0[cand]) begin
                found_p0 = 1'b1;
                win_p0   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        release_g  = 1'b0;
        case (state)
            IDLE: begin
                if (found_p0) begin
                    take       = 1'b1;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_id]) begin
                    release_g  = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ---- stage p1: registered grant, decode and pointer ----
    // sel and grant_id are left untouched on release so the mux keeps a stable
    // steering value through the idle cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            grant    <= '0;
            grant_id <= '0;
            sel      <= '0;
            dec_err  <= 1'b0;
            busy     <= 1'b0;
        end else if (take) begin
            grant    <= NUM_MASTERS'(1) << win_p0;
            grant_id <= win_p0;
            sel      <= top_idx[win_p0];
            dec_err  <= (int'(top_idx[win_p0]) >= NUM_SLAVES);
            busy     <= 1'b1;
        end else if (release_g) begin
            grant    <= '0;
            busy     <= 1'b0;
            dec_err  <= 1'b0;
            ptr      <= MW'((int'(grant_id) + 1) % NUM_MASTERS);
        end
    end

    // Decode-error grants still occupy a slot; the default slave's error
    // response produces the done pulse that frees it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_MASTERS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++)
                cnt[i] <= cnt_update(cnt[i], take && (win_p0 == MW'(i)), done[i]);
        end
    end

endmodule

// File: tb/tb_axi_rr_addr_arbiter.sv
`timescale 1ns/1ps
module tb_axi_rr_addr_arbiter;
    localparam int NM   = 4;
    localparam int NS   = 3;
    localparam int AW   = 32;
    localparam int MAXO = 4;
    localparam int CW   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NM-1:0]     req;
    logic [NM-1:0]     done;
    logic [NM*AW-1:0]  addr;
    logic [NM-1:0]     grant;
    logic [1:0]        grant_id;
    logic [1:0]        sel;
    logic              dec_err;
    logic              busy;
    logic [NM*CW-1:0]  outstanding;

    int checks   = 0;
    int failures = 0;

    axi_rr_addr_arbiter #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .done(done),
        .grant(grant), .grant_id(grant_id), .sel(sel), .dec_err(dec_err),
        .busy(busy), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // ---------------- behavioural reference model ----------------
    int m_cnt [NM];
    bit m_busy;
    bit m_derr;
    int m_gid;
    int m_ptr;
    int m_sel;

    task automatic model_reset();
        for (int i = 0; i < NM; i++) m_cnt[i] = 0;
        m_busy = 0; m_derr = 0; m_gid = 0; m_ptr = 0; m_sel = 0;
    endtask

    function automatic int top_of(int i);
        logic [1:0] t;
        t = addr[i*AW + AW - 2 +: 2];
        return int'(t);
    endfunction

    // Applies the arbitration rules to the inputs present before the edge.
    task automatic model_edge();
        int inc;
        int c;
        bit d;
        inc = -1;
        if (!m_busy) begin
            for (int k = 0; k < NM; k++) begin
                c = (m_ptr + k) % NM;
                if (req[c] && m_cnt[c] < MAXO) begin
                    m_busy = 1; m_gid = c; m_sel = top_of(c);
                    m_derr = (m_sel >= NS); inc = c;
                    break;
                end
            end
        end else if (!req[m_gid]) begin
            m_busy = 0; m_derr = 0; m_ptr = (m_gid + 1) % NM;
        end
        for (int i = 0; i < NM; i++) begin
            d = done[i] && (m_cnt[i] > 0);
            if (i == inc && !d) m_cnt[i] = m_cnt[i] + 1;
            else if (i != inc && d) m_cnt[i] = m_cnt[i] - 1;
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        logic [NM-1:0]    eg;
        logic [NM*CW-1:0] eo;
        eg = m_busy ? NM'(1 << m_gid) : '0;
        for (int i = 0; i < NM; i++) eo[i*CW +: CW] = CW'(m_cnt[i]);
        chk({tag, " grant"},       32'(grant),       32'(eg));
        chk({tag, " grant_id"},    32'(grant_id),    32'(m_gid));
        chk({tag, " sel"},         32'(sel),         32'(m_sel));
        chk({tag, " dec_err"},     32'(dec_err),     32'(m_derr));
        chk({tag, " busy"},        32'(busy),        32'(m_busy));
        chk({tag, " outstanding"}, 32'(outstanding), 32'(eo));
    endtask

    task automatic set_tops(logic [7:0] t);
        for (int i = 0; i < NM; i++)
            addr[i*AW +: AW] = {t[i*2 +: 2], 30'($urandom)};
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  r;
        logic [3:0]  d;
        logic [7:0]  t;
        logic [3:0]  g;
        logic        b;
        logic [1:0]  s;
        logic        e;
        logic [11:0] o;
    } vec_t;

    vec_t vq[$];

    task automatic add(logic [3:0] r, logic [3:0] d, logic [7:0] t, logic [3:0] g,
                       logic b, logic [1:0] s, logic e,
                       int c3, int c2, int c1, int c0);
        vec_t v;
        v.r = r; v.d = d; v.t = t; v.g = g; v.b = b; v.s = s; v.e = e;
        v.o = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
        vq.push_back(v);
    endtask

    initial begin
        // rotation as each request drops and rises again
        add(4'hF, 4'h0, 8'h00, 4'h1, 1, 0, 0, 0, 0, 0, 1);
        add(4'hE, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 1);
        add(4'hF, 4'h0, 8'h00, 4'h2, 1, 0, 0, 0, 0, 1, 1);
        add(4'hD, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 1, 1);
        add(4'hF, 4'h0, 8'h00, 4'h4, 1, 0, 0, 0, 1, 1, 1);
        add(4'hB, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 1, 1, 1);
        add(4'hF, 4'h0, 8'h00, 4'h8, 1, 0, 0, 1, 1, 1, 1);
        add(4'h7, 4'h0, 8'h00, 4'h0, 0, 0, 0, 1, 1, 1, 1);
        add(4'h0, 4'hF, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        // lone request skips idle masters; release moves ptr to 3
        add(4'h4, 4'h0, 8'h00, 4'h4, 1, 0, 0, 0, 1, 0, 0);
        add(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 1, 0, 0);
        add(4'h9, 4'h4, 8'h00, 4'h8, 1, 0, 0, 1, 0, 0, 0);
        add(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 1, 0, 0, 0);
        add(4'h0, 4'h8, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        // master 1 fills its cap, master 3 proceeds, done frees a slot
        add(4'h2, 4'h0, 8'h00, 4'h2, 1, 0, 0, 0, 0, 1, 0);
        add(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 1, 0);
        add(4'h2, 4'h0, 8'h00, 4'h2, 1, 0, 0, 0, 0, 2, 0);
        add(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 2, 0);
        add(4'h2, 4'h0, 8'h00, 4'h2, 1, 0, 0, 0, 0, 3, 0);
        add(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 3, 0);
        add(4'h2, 4'h0, 8'h00, 4'h2, 1, 0, 0, 0, 0, 4, 0);
        add(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 4, 0);
        add(4'h2, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 4, 0);
        add(4'hA, 4'h0, 8'h00, 4'h8, 1, 0, 0, 1, 0, 4, 0);
        add(4'h2, 4'h0, 8'h00, 4'h0, 0, 0, 0, 1, 0, 4, 0);
        add(4'h2, 4'h2, 8'h00, 4'h0, 0, 0, 0, 1, 0, 3, 0);
        add(4'h2, 4'h0, 8'h00, 4'h2, 1, 0, 0, 1, 0, 4, 0);
        add(4'h0, 4'hA, 8'h00, 4'h0, 0, 0, 0, 0, 0, 3, 0);
        add(4'h0, 4'h2, 8'h00, 4'h0, 0, 0, 0, 0, 0, 2, 0);
        add(4'h0, 4'h2, 8'h00, 4'h0, 0, 0, 0, 0, 0, 1, 0);
        add(4'h0, 4'h2, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        // decode: top bits 11 -> dec_err, held against address change; 10 -> sel 2
        add(4'h1, 4'h0, 8'h03, 4'h1, 1, 3, 1, 0, 0, 0, 1);
        add(4'h1, 4'h0, 8'h02, 4'h1, 1, 3, 1, 0, 0, 0, 1);
        add(4'h0, 4'h0, 8'h02, 4'h0, 0, 3, 0, 0, 0, 0, 1);
        add(4'h1, 4'h0, 8'h02, 4'h1, 1, 2, 0, 0, 0, 0, 2);
        add(4'h0, 4'h0, 8'h02, 4'h0, 0, 2, 0, 0, 0, 0, 2);
        // same-cycle grant and done keeps count; done at zero saturates
        add(4'h1, 4'h1, 8'h00, 4'h1, 1, 0, 0, 0, 0, 0, 2);
        add(4'h0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 2);
        add(4'h0, 4'h1, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 1);
        add(4'h0, 4'h1, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        add(4'h0, 4'h1, 8'h00, 4'h0, 0, 0, 0, 0, 0, 0, 0);

        // reset with everyone requesting
        rst = 1'b0; req = 4'hF; done = 4'h0; set_tops(8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset grant",       32'(grant),       32'h0);
        chk("reset busy",        32'(busy),        32'h0);
        chk("reset outstanding", 32'(outstanding), 32'h0);
        chk("reset dec_err",     32'(dec_err),     32'h0);
        rst = 1'b1;

        foreach (vq[n]) begin
            req = vq[n].r; done = vq[n].d; set_tops(vq[n].t);
            step();
            chk($sformatf("vec%0d grant", n),       32'(grant),       32'(vq[n].g));
            chk($sformatf("vec%0d busy", n),        32'(busy),        32'(vq[n].b));
            chk($sformatf("vec%0d sel", n),         32'(sel),         32'(vq[n].s));
            chk($sformatf("vec%0d dec_err", n),     32'(dec_err),     32'(vq[n].e));
            chk($sformatf("vec%0d outstanding", n), 32'(outstanding), 32'(vq[n].o));
        end
        done = 4'h0;

        // asynchronous reset in the middle of a grant
        req = 4'h4;
        step();
        chk("midrst pre grant", 32'(grant), 32'h4);
        #2 rst = 1'b0;
        #1;
        chk("midrst async grant",       32'(grant),       32'h0);
        chk("midrst async busy",        32'(busy),        32'h0);
        chk("midrst async outstanding", 32'(outstanding), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; req = 4'hF;
        step();
        chk("midrst restart grant", 32'(grant), 32'h1);
        chk_model("midrst restart");

        // randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req = 4'($urandom);
            for (int i = 0; i < NM; i++) done[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) set_tops(8'($urandom));
            if (cyc == 1500) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                chk_model("rand async reset");
                @(posedge clk);
                #1;
                rst = 1'b1;
            end
            step();
            chk_model($sformatf("rand%0d", cyc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
